// File: rtl/zapper_sense.sv
// ----------------------------------------------------------------------------
// zapper_sense
//
// Emulates the NES Zapper photodiode and trigger from a host-supplied aim
// point. The PPU pixel stream is watched inside a square window around the
// aim point; a window line with enough bright pixels fires the light sense,
// which then stays asserted for a fixed number of scanlines. The block also
// produces the crosshair overlay code for the video stage.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   ce_pix      one-clock pixel strobe, all pixel sampling happens on it
//   enable      gun attached; low forces light and reticle to 0
//   color       PPU palette index of the current pixel
//   count_h     PPU dot (0..340)
//   count_v     PPU line (511 = pre-render)
//   pos_x       aim X, 0..255 on-screen
//   pos_y       aim Y, 0..239 on-screen
//   trigger_in  raw asynchronous trigger button
//   light       photodiode sees light (active high)
//   trigger     debounced trigger (active high)
//   reticle     bit0 = draw crosshair, bit1 = trigger-held colour
// ----------------------------------------------------------------------------
module zapper_sense #(
    parameter int RADIUS      = 4,
    parameter int THRESH      = 4,
    parameter int LIGHT_LINES = 26,
    parameter int DEBOUNCE    = 65535,
    parameter int CROSS       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       enable,
    input  logic [5:0] color,
    input  logic [8:0] count_h,
    input  logic [8:0] count_v,
    input  logic [8:0] pos_x,
    input  logic [8:0] pos_y,
    input  logic       trigger_in,
    output logic       light,
    output logic       trigger,
    output logic [1:0] reticle
);

    localparam int LW = $clog2(LIGHT_LINES + 1);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SENSE,
        HOLD,
        RESENSE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      brightCnt_q, brightCnt_d;
    logic [LW-1:0]   lineCnt_q, lineCnt_d;
    logic [8:0]      prevV_q, prevV_d;
    logic            light_q, light_d;
    logic [1:0]      reticle_q, reticle_d;
    logic            sync1_q, sync2_q;
    logic            trigger_q, trigger_d;
    logic [DW-1:0]   debCnt_q, debCnt_d;

    logic [9:0] hExt, vExt, pxExt, pyExt;
    logic [9:0] xLo, xHi, yLo, yHi, xHiRaw, yHiRaw;
    logic [9:0] dx, dy;
    logic       onScreen, bright, lineTick, inX, inY, entry, atXHi, pass, retOn;
    logic [3:0] startCnt, countNext;

    // Window geometry and pixel classification. Everything is widened to
    // 10 bits so that subtracting the radius near the screen edge clamps
    // to 0 instead of wrapping into the high dot numbers.
    always_comb begin
        hExt     = {1'b0, count_h};
        vExt     = {1'b0, count_v};
        pxExt    = {1'b0, pos_x};
        pyExt    = {1'b0, pos_y};
        xLo      = (pxExt < 10'(RADIUS)) ? 10'd0 : (pxExt - 10'(RADIUS));
        yLo      = (pyExt < 10'(RADIUS)) ? 10'd0 : (pyExt - 10'(RADIUS));
        xHiRaw   = pxExt + 10'(RADIUS);
        yHiRaw   = pyExt + 10'(RADIUS);
        xHi      = (xHiRaw > 10'd255) ? 10'd255 : xHiRaw;
        yHi      = (yHiRaw > 10'd239) ? 10'd239 : yHiRaw;
        onScreen = (pxExt <= 10'd255) && (pyExt <= 10'd239);
        bright   = (color[5:4] >= 2'd2) && (color[3:0] <= 4'hC);
        lineTick = ce_pix && (count_v != prevV_q);
        inY      = onScreen && (vExt >= yLo) && (vExt <= yHi);
        inX      = (hExt >= xLo) && (hExt <= xHi);
        entry    = inY && (hExt == xLo);
        atXHi    = (hExt == xHi);
        startCnt = bright ? 4'd1 : 4'd0;
        if (inX && bright) begin
            countNext = (brightCnt_q == 4'hF) ? 4'hF : (brightCnt_q + 4'd1);
        end else begin
            countNext = brightCnt_q;
        end
        pass     = (countNext >= 4'(THRESH));
        dx       = (hExt >= pxExt) ? (hExt - pxExt) : (pxExt - hExt);
        dy       = (vExt >= pyExt) ? (vExt - pyExt) : (pyExt - vExt);
        retOn    = enable && onScreen &&
                   (((vExt == pyExt) && (dx <= 10'(CROSS))) ||
                    ((hExt == pxExt) && (dy <= 10'(CROSS))));
    end

    // Sensing state machine. HOLD keeps light asserted while counting down
    // scanlines; RESENSE is HOLD with a window line being re-evaluated, so
    // a passing line refreshes the hold and a failing one leaves it alone.
    // A line tick aborts any evaluation in progress, and the tick that runs
    // the hold out may immediately start sensing on the new line.
    always_comb begin
        state_d     = state_q;
        brightCnt_d = brightCnt_q;
        lineCnt_d   = lineCnt_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (ce_pix) begin
            unique case (state_q)
                IDLE: begin
                    if (entry) begin
                        state_d     = SENSE;
                        brightCnt_d = startCnt;
                    end
                end
                SENSE: begin
                    if (lineTick) begin
                        state_d = IDLE;
                    end else begin
                        brightCnt_d = countNext;
                        if (atXHi) begin
                            if (pass) begin
                                state_d   = HOLD;
                                lineCnt_d = LW'(LIGHT_LINES);
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                HOLD, RESENSE: begin
                    if (lineTick && (lineCnt_q <= LW'(1))) begin
                        lineCnt_d = '0;
                        if (entry) begin
                            state_d     = SENSE;
                            brightCnt_d = startCnt;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if ((state_q == RESENSE) && !lineTick) begin
                        brightCnt_d = countNext;
                        if (atXHi) begin
                            state_d = HOLD;
                            if (pass) begin
                                lineCnt_d = LW'(LIGHT_LINES);
                            end
                        end
                    end else begin
                        if (lineTick) begin
                            lineCnt_d = lineCnt_q - LW'(1);
                        end
                        if (entry) begin
                            state_d     = RESENSE;
                            brightCnt_d = startCnt;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Light follows the next state directly so it rises on the same edge
    // that samples the last window pixel. The previous line number and the
    // crosshair code only move on pixel strobes; detaching the gun clears
    // the crosshair at once.
    always_comb begin
        light_d = enable && ((state_d == HOLD) || (state_d == RESENSE));
        prevV_d = ce_pix ? count_v : prevV_q;
        if (!enable) begin
            reticle_d = 2'b00;
        end else if (ce_pix) begin
            reticle_d = {retOn && trigger_q, retOn};
        end else begin
            reticle_d = reticle_q;
        end
    end

    // Trigger debounce. The counter only runs while the synchronised button
    // disagrees with the published trigger, so any bounce shorter than the
    // terminal count resets it and leaves the trigger unchanged.
    always_comb begin
        trigger_d = trigger_q;
        debCnt_d  = debCnt_q;
        if (sync2_q == trigger_q) begin
            debCnt_d = '0;
        end else if (debCnt_q == DW'(DEBOUNCE - 1)) begin
            trigger_d = sync2_q;
            debCnt_d  = '0;
        end else begin
            debCnt_d = debCnt_q + DW'(1);
        end
    end

    // All state registers, cleared together by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            brightCnt_q <= '0;
            lineCnt_q   <= '0;
            prevV_q     <= '0;
            light_q     <= 1'b0;
            reticle_q   <= 2'b00;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            trigger_q   <= 1'b0;
            debCnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            brightCnt_q <= brightCnt_d;
            lineCnt_q   <= lineCnt_d;
            prevV_q     <= prevV_d;
            light_q     <= light_d;
            reticle_q   <= reticle_d;
            sync1_q     <= trigger_in;
            sync2_q     <= sync1_q;
            trigger_q   <= trigger_d;
            debCnt_q    <= debCnt_d;
        end
    end

    assign light   = light_q;
    assign trigger = trigger_q;
    assign reticle = reticle_q;

endmodule
